// File: rtl/ahb_matrix_arbiter_if.sv
// Bus bundle between the AHB masters/slaves and the matrix arbiter.
// The master modport is the traffic side (drives requests and slave ready),
// the slave modport is the arbiter itself (returns grants and owner ids).
interface ahb_matrix_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr;
  logic [NUM_MASTERS*2-1:0]          m_htrans;
  logic [NUM_MASTERS-1:0]            m_hmastlock;
  logic [NUM_SLAVES-1:0]             s_hready;
  logic [NUM_MASTERS-1:0]            m_hgrant;
  logic [NUM_SLAVES-1:0]             s_hsel;
  logic [NUM_SLAVES*MW-1:0]          s_addr_owner;
  logic [NUM_SLAVES*MW-1:0]          s_data_owner;
  logic [NUM_SLAVES-1:0]             s_data_valid;

  modport master (
    output m_haddr, m_htrans, m_hmastlock, s_hready,
    input  m_hgrant, s_hsel, s_addr_owner, s_data_owner, s_data_valid
  );

  modport slave (
    input  m_haddr, m_htrans, m_hmastlock, s_hready,
    output m_hgrant, s_hsel, s_addr_owner, s_data_owner, s_data_valid
  );
endinterface

// File: rtl/ahb_matrix_arbiter.sv
// Multi-master / multi-slave AHB arbitration and address decode core.
// Each slave runs its own FREE/OWNED ownership FSM with round-robin or fixed
// priority arbitration, burst/lock-aware release, a forced-release hold
// limit, and a data-phase owner tracker for the downstream muxes.
module ahb_matrix_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int MAX_HOLD    = 16
) (
  input logic                 hclk,
  input logic                 hresetn,
  ahb_matrix_arbiter_if.slave bus
);
  localparam int MW = $clog2(NUM_MASTERS);
  localparam int SW = $clog2(NUM_SLAVES);
  // Counter only needs to reach MAX_HOLD; keep one bit when the limit is off.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {FREE = 1'b0, OWNED = 1'b1} state_t;

  logic [1:0]                             m_trans [NUM_MASTERS];
  logic [SW-1:0]                          m_slave [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]                 m_lock;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] req_mat;
  logic [NUM_SLAVES-1:0]                  slave_owned;
  logic [NUM_SLAVES-1:0][MW-1:0]          slave_owner;

  // Only the region-select bits of the address take part in decoding.
  logic unused_addr;
  assign unused_addr = ^bus.m_haddr;

  genvar gi;

  // Unpack per-master fields and decode the target slave from the top bits.
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign m_trans[gi] = bus.m_htrans[gi*2 +: 2];
      assign m_slave[gi] = bus.m_haddr[gi*ADDR_WIDTH + ADDR_WIDTH - 1 -: SW];
      assign m_lock[gi]  = bus.m_hmastlock[gi];
    end
  endgenerate

  // Request matrix: a master requests exactly the slave its address decodes to.
  always_comb begin
    req_mat = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        req_mat[s][i] = (m_trans[i] != HTRANS_IDLE) && (m_slave[i] == SW'(s));
      end
    end
  end

  // A master is granted while any slave lists it as address-phase owner.
  always_comb begin
    bus.m_hgrant = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (slave_owned[s] && (slave_owner[s] == MW'(i))) begin
          bus.m_hgrant[i] = 1'b1;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      state_t                 state_reg;
      logic [MW-1:0]          owner_reg;
      logic [MW-1:0]          ptr_reg;
      logic [CW-1:0]          hold_reg;
      logic                   data_valid_reg;
      logic [MW-1:0]          data_owner_reg;
      logic [NUM_MASTERS-1:0] owner_mask;
      logic [NUM_MASTERS-1:0] cand;
      logic [1:0]             own_trans;
      logic                   own_lock;
      logic                   own_away;
      logic                   others_req;
      logic                   release_now;
      logic                   win_any;
      logic [MW-1:0]          win_idx;

      // Release decision for the current owner; the owner is excluded from the
      // candidate set so a release hands over without a FREE gap.
      always_comb begin
        owner_mask  = NUM_MASTERS'(1) << owner_reg;
        own_trans   = m_trans[owner_reg];
        own_lock    = m_lock[owner_reg];
        own_away    = (m_slave[owner_reg] != SW'(gi));
        others_req  = |(req_mat[gi] & ~owner_mask);
        release_now = (state_reg == OWNED) &&
                      (((own_trans == HTRANS_IDLE) && !own_lock) ||
                       own_away ||
                       ((MAX_HOLD != 0) && (hold_reg >= HOLD_LIMIT) && !own_lock &&
                        others_req &&
                        ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_IDLE))));
        cand        = (state_reg == OWNED) ? (req_mat[gi] & ~owner_mask) : req_mat[gi];
      end

      // Winner selection; loops run from last to first in search order so the
      // final assignment is the highest-priority candidate.
      always_comb begin
        int idx;
        idx     = 0;
        win_any = 1'b0;
        win_idx = '0;
        if (ARB_MODE == 1) begin
          for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (cand[k]) begin
              win_any = 1'b1;
              win_idx = MW'(k);
            end
          end
        end else begin
          for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_MASTERS) begin
              idx = idx - NUM_MASTERS;
            end
            if (cand[idx]) begin
              win_any = 1'b1;
              win_idx = MW'(idx);
            end
          end
        end
      end

      // Ownership FSM, hold counter, RR pointer and data-phase tracking;
      // everything freezes while the slave stretches its transfer.
      always_ff @(posedge hclk) begin
        if (!hresetn) begin
          state_reg      <= FREE;
          owner_reg      <= '0;
          ptr_reg        <= MW'(NUM_MASTERS - 1);
          hold_reg       <= '0;
          data_valid_reg <= 1'b0;
          data_owner_reg <= '0;
        end else if (bus.s_hready[gi]) begin
          data_valid_reg <= (state_reg == OWNED) && own_trans[1];
          data_owner_reg <= (state_reg == OWNED) ? owner_reg : '0;
          if ((state_reg == FREE) || release_now) begin
            if (win_any) begin
              state_reg <= OWNED;
              owner_reg <= win_idx;
              hold_reg  <= '0;
              if (ARB_MODE == 0) begin
                ptr_reg <= win_idx;
              end
            end else begin
              state_reg <= FREE;
              owner_reg <= '0;
            end
          end else if (hold_reg < HOLD_LIMIT) begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
      end

      assign slave_owned[gi]                 = (state_reg == OWNED);
      assign slave_owner[gi]                 = owner_reg;
      assign bus.s_hsel[gi]                  = (state_reg == OWNED);
      assign bus.s_addr_owner[gi*MW +: MW]   = owner_reg;
      assign bus.s_data_valid[gi]            = data_valid_reg;
      assign bus.s_data_owner[gi*MW +: MW]   = data_owner_reg;
    end
  endgenerate
endmodule

// File: tb/tb_ahb_matrix_arbiter.sv
// Bench for ahb_matrix_arbiter: one round-robin instance (hold limit 4) and
// one fixed-priority instance (hold limit off) share the same stimulus and
// are each compared every cycle against a rule-level ownership model.
module tb_ahb_matrix_arbiter;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int MW = 2;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_matrix_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW)) ifc_rr ();
  ahb_matrix_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW)) ifc_fx ();

  ahb_matrix_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW),
                       .ARB_MODE(0), .MAX_HOLD(4)) dut_rr (
    .hclk(hclk), .hresetn(hresetn), .bus(ifc_rr.slave));
  ahb_matrix_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW),
                       .ARB_MODE(1), .MAX_HOLD(0)) dut_fx (
    .hclk(hclk), .hresetn(hresetn), .bus(ifc_fx.slave));

  // observed outputs, index 0 = round-robin instance, 1 = fixed instance
  logic [NM-1:0]    o_gnt [2];
  logic [NS-1:0]    o_sel [2];
  logic [NS-1:0]    o_dv  [2];
  logic [NS*MW-1:0] o_ao  [2];
  logic [NS*MW-1:0] o_do  [2];
  assign o_gnt[0] = ifc_rr.m_hgrant;      assign o_gnt[1] = ifc_fx.m_hgrant;
  assign o_sel[0] = ifc_rr.s_hsel;        assign o_sel[1] = ifc_fx.s_hsel;
  assign o_dv[0]  = ifc_rr.s_data_valid;  assign o_dv[1]  = ifc_fx.s_data_valid;
  assign o_ao[0]  = ifc_rr.s_addr_owner;  assign o_ao[1]  = ifc_fx.s_addr_owner;
  assign o_do[0]  = ifc_rr.s_data_owner;  assign o_do[1]  = ifc_fx.s_data_owner;

  // stimulus state
  logic [1:0]    tr [NM];
  logic [31:0]   ad [NM];
  logic          lk [NM];
  logic [NS-1:0] hr;
  int            beat [NM];
  int            blen [NM];

  // reference model: owner per slave (-1 = free), hold count, RR pointer, data phase
  int    md_mode [2] = '{0, 1};
  int    md_max  [2] = '{4, 0};
  string dn      [2] = '{"rr", "fx"};
  int    mo_own  [2][NS];
  int    mo_hold [2][NS];
  int    mo_ptr  [2][NS];
  bit    mo_dv   [2][NS];
  int    mo_dow  [2][NS];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // region = address divided by region size
  function automatic int dec(input logic [31:0] a);
    return int'(a / 32'h4000_0000);
  endfunction

  function automatic bit wants(input int m, input int s);
    return (tr[m] != IDLE) && (dec(ad[m]) == s);
  endfunction

  function automatic int pick(input int d, input int s, input int excl);
    int m;
    for (int k = 1; k <= NM; k++) begin
      m = (md_mode[d] == 1) ? (k - 1) : ((mo_ptr[d][s] + k) % NM);
      if (m != excl && wants(m, s)) return m;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  o, w;
    bit  rel, oth;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < NS; s++) begin
        if (!hresetn) begin
          mo_own[d][s] = -1; mo_hold[d][s] = 0; mo_ptr[d][s] = NM - 1;
          mo_dv[d][s] = 1'b0; mo_dow[d][s] = 0;
        end else if (hr[s]) begin
          o = mo_own[d][s];
          mo_dv[d][s]  = (o >= 0) && (tr[o] == NSEQ || tr[o] == SEQ);
          mo_dow[d][s] = (o >= 0) ? o : 0;
          if (o < 0) begin
            rel = 1'b1;
          end else begin
            oth = 1'b0;
            for (int m = 0; m < NM; m++) if (m != o && wants(m, s)) oth = 1'b1;
            rel = (tr[o] == IDLE && !lk[o]) || (dec(ad[o]) != s) ||
                  (md_max[d] != 0 && mo_hold[d][s] >= md_max[d] && !lk[o] && oth &&
                   (tr[o] == NSEQ || tr[o] == IDLE));
          end
          if (rel) begin
            w = pick(d, s, o);
            mo_own[d][s] = w;
            if (w >= 0) begin
              mo_hold[d][s] = 0;
              if (md_mode[d] == 0) mo_ptr[d][s] = w;
              if (d == 0) $display("cycle %0d rr grant slave %0d -> master %0d", cyc + 1, s, w);
            end
          end else if (mo_hold[d][s] < md_max[d]) begin
            mo_hold[d][s]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NM-1:0] ge;
    logic [NS-1:0] se, de;
    for (int d = 0; d < 2; d++) begin
      ge = '0; se = '0; de = '0;
      for (int s = 0; s < NS; s++) begin
        if (mo_own[d][s] >= 0) begin
          ge[mo_own[d][s]] = 1'b1;
          se[s] = 1'b1;
        end
        de[s] = mo_dv[d][s];
      end
      check_val({dn[d], "_gnt"}, int'(o_gnt[d]), int'(ge));
      check_val({dn[d], "_hsel"}, int'(o_sel[d]), int'(se));
      check_val({dn[d], "_dvalid"}, int'(o_dv[d]), int'(de));
      for (int s = 0; s < NS; s++) begin
        if (mo_own[d][s] >= 0)
          check_val($sformatf("%s_aowner%0d", dn[d], s), int'(o_ao[d][s*MW +: MW]), mo_own[d][s]);
        if (mo_dv[d][s])
          check_val($sformatf("%s_downer%0d", dn[d], s), int'(o_do[d][s*MW +: MW]), mo_dow[d][s]);
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NM; i++) begin
      ifc_rr.m_haddr[i*AW +: AW] = ad[i];  ifc_fx.m_haddr[i*AW +: AW] = ad[i];
      ifc_rr.m_htrans[i*2 +: 2]  = tr[i];  ifc_fx.m_htrans[i*2 +: 2]  = tr[i];
      ifc_rr.m_hmastlock[i]      = lk[i];  ifc_fx.m_hmastlock[i]      = lk[i];
    end
    ifc_rr.s_hready = hr;
    ifc_fx.s_hready = hr;
  endtask

  task automatic cycle();
    apply();
    @(posedge hclk);
    model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic setm(input int i, input logic [1:0] t, input logic [31:0] a, input logic l);
    tr[i] = t; ad[i] = a; lk[i] = l;
  endtask

  task automatic idle_all(input int n);
    for (int i = 0; i < NM; i++) setm(i, IDLE, 32'h0, 1'b0);
    hr = '1;
    repeat (n) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_val({tag, "_", dn[d], "_gnt"}, int'(o_gnt[d]), 0);
      check_val({tag, "_", dn[d], "_hsel"}, int'(o_sel[d]), 0);
      check_val({tag, "_", dn[d], "_dvalid"}, int'(o_dv[d]), 0);
      check_val({tag, "_", dn[d], "_aowner"}, int'(o_ao[d]), 0);
      check_val({tag, "_", dn[d], "_downer"}, int'(o_do[d]), 0);
    end
  endtask

  // Master 2 runs INCR4 bursts to slave 3 while master 0 waits; returns the
  // number of edges after the initial grant until master 0 owns slave 3.
  task automatic burst_run(input logic lock_b, input int stop_beat, output int edges);
    int b;
    edges = 0;
    setm(2, NSEQ, 32'hC000_0000, lock_b);
    cycle();
    check_val("burst_first_owner", int'(o_ao[0][7:6]), 2);
    setm(0, NSEQ, 32'hC000_0100, 1'b0);
    b = 1;
    while (edges < 40) begin
      if (stop_beat > 0 && b >= stop_beat) setm(2, IDLE, 32'hC000_0000, 1'b0);
      else setm(2, (b % 4 == 0) ? NSEQ : SEQ, 32'hC000_0000 + 32'(4 * (b % 4)), lock_b);
      cycle();
      edges++;
      if (o_sel[0][3] && o_ao[0][7:6] == 2'd0) break;
      if (mo_own[0][3] == 2) b++;
    end
  endtask

  task automatic start_burst(input int i);
    int s;
    s = $urandom_range(NS - 1);
    blen[i] = $urandom_range(4, 1);
    beat[i] = 0;
    setm(i, NSEQ, (32'(s) << 30) | ($urandom() & 32'h3FFF_FFFC), ($urandom_range(3) == 0));
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int edges;
    int s;

    for (int i = 0; i < NM; i++) setm(i, IDLE, 32'h0, 1'b0);
    hr = '1;
    hresetn = 1'b0;
    cycle();
    cycle();
    check_all_zero("reset");

    // single master, first grant latency and data phase
    hresetn = 1'b1;
    setm(0, NSEQ, 32'h0000_0010, 1'b0);
    cycle();
    check_val("first_hsel0", int'(o_sel[0][0]), 1);
    check_val("first_aowner0", int'(o_ao[0][1:0]), 0);
    check_val("first_gnt", int'(o_gnt[0]), 1);
    setm(0, SEQ, 32'h0000_0014, 1'b0);
    cycle();
    check_val("first_dvalid0", int'(o_dv[0][0]), 1);
    check_val("first_downer0", int'(o_do[0][1:0]), 0);
    idle_all(2);

    // round-robin rotation on slave 1, owner goes IDLE right after its grant
    for (int i = 0; i < NM; i++) setm(i, NSEQ, 32'h4000_0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val($sformatf("rr_order%0d", k), int'(o_ao[0][3:2]), exp_order[k]);
      for (int i = 0; i < NM; i++)
        setm(i, (i == mo_own[0][1]) ? IDLE : NSEQ, 32'h4000_0000, 1'b0);
    end
    idle_all(2);

    // fixed priority on slave 2: master 1 beats master 3 and keeps ownership
    setm(1, NSEQ, 32'h8000_0000, 1'b0);
    setm(3, NSEQ, 32'h8000_0020, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_val($sformatf("fx_keep%0d", k), int'(o_ao[1][5:4]), 1);
    end
    setm(1, IDLE, 32'h8000_0000, 1'b0);
    cycle();
    check_val("fx_handover", int'(o_ao[1][5:4]), 3);
    check_val("fx_handover_hsel", int'(o_sel[1][2]), 1);
    idle_all(2);

    // hold limit forces release at a burst boundary; a lock defeats it
    burst_run(1'b0, 0, edges);
    check_val("hold_limit_edges", edges, 8);
    idle_all(3);
    burst_run(1'b1, 12, edges);
    check_val("locked_edges", edges, 12);
    idle_all(3);

    // stretched slave 0 freezes ownership until hready returns
    setm(1, NSEQ, 32'h0000_0040, 1'b0);
    cycle();
    check_val("stall_owner_before", int'(o_ao[0][1:0]), 1);
    hr[0] = 1'b0;
    setm(1, IDLE, 32'h0000_0040, 1'b0);
    setm(3, NSEQ, 32'h0000_0080, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val($sformatf("stall_owner%0d", k), int'(o_ao[0][1:0]), 1);
    end
    hr[0] = 1'b1;
    cycle();
    check_val("stall_rr_handover", int'(o_ao[0][1:0]), 3);
    check_val("stall_fx_handover", int'(o_ao[1][1:0]), 3);
    idle_all(2);

    // reset in the middle of bursts, then a fresh contention
    setm(1, NSEQ, 32'h8000_0000, 1'b0);
    setm(2, NSEQ, 32'h4000_0000, 1'b0);
    cycle();
    setm(1, SEQ, 32'h8000_0004, 1'b0);
    cycle();
    hresetn = 1'b0;
    cycle();
    check_all_zero("midreset");
    hresetn = 1'b1;
    for (int i = 0; i < NM; i++) setm(i, NSEQ, 32'h4000_0100, 1'b0);
    cycle();
    check_val("post_reset_rr_owner", int'(o_ao[0][3:2]), 0);
    check_val("post_reset_fx_owner", int'(o_ao[1][3:2]), 0);
    check_val("post_reset_rr_gnt", int'(o_gnt[0]), 1);
    idle_all(2);

    // randomized traffic: masters hold their address phase until owned
    for (int i = 0; i < NM; i++) begin
      beat[i] = 0;
      blen[i] = 1;
    end
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NM; i++) begin
        s = dec(ad[i]);
        if (tr[i] == IDLE) begin
          if ($urandom_range(2) == 0) start_burst(i);
        end else if (mo_own[0][s] == i && hr[s]) begin
          beat[i]++;
          if (beat[i] < blen[i]) setm(i, SEQ, ad[i] + 32'd4, lk[i]);
          else if ($urandom_range(1) == 1) start_burst(i);
          else setm(i, IDLE, ad[i], 1'b0);
        end
      end
      for (int j = 0; j < NS; j++) hr[j] = ($urandom_range(3) != 0);
      hresetn = ($urandom_range(299) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ahb_matrix_arbiter.md
# ahb_matrix_arbiter

Parametrised multi-master, multi-slave AHB arbitration and decode core for the AHB interconnect. Decodes each master's address to one slave region, arbitrates per slave with selectable round-robin or fixed priority, holds ownership across bursts and locked sequences, and forces release after a configurable hold limit. It also tracks the data-phase owner of every slave for the downstream read/response muxes.

## Interface
- NUM_MASTERS, 4, number of AHB masters (≥2)
- NUM_SLAVES, 4, number of slaves; power of two, ≥2
- ADDR_WIDTH, 32, address width
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest)
- MAX_HOLD, 16, ownership hold limit in hready-high cycles; 0 disables forced release
- MW (local) = $clog2(NUM_MASTERS)
- hclk  in  1  clock, all logic on rising edge
- hresetn  in  1  reset, synchronous, active-low
- m_haddr  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_htrans  in  NUM_MASTERS*2  per-master HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- m_hmastlock  in  NUM_MASTERS  per-master lock
- s_hready  in  NUM_SLAVES  per-slave HREADYOUT
- m_hgrant  out  NUM_MASTERS  master i currently owns its decoded slave
- s_hsel  out  NUM_SLAVES  slave has an address-phase owner
- s_addr_owner  out  NUM_SLAVES*MW  address-phase owner id
- s_data_owner  out  NUM_SLAVES*MW  data-phase owner id
- s_data_valid  out  NUM_SLAVES  data phase in progress on slave

## Operation
- Decode: slave index = m_haddr[ADDR_WIDTH-1 -: $clog2(NUM_SLAVES)]; equal-sized regions.
- Request: master i requests slave s when htrans != IDLE and decode == s. A master requests at most one slave.
- Per-slave FSM, states FREE / OWNED:
  - FREE: s_hsel=0. If any request and s_hready[s]=1, grant the winner, load owner, clear hold counter, go OWNED.
  - OWNED: release (go FREE, or regrant in the same edge) when s_hready[s]=1 and any of:
    - (a) owner htrans == IDLE and owner hmastlock == 0
    - (b) owner decodes to a different slave
    - (c) MAX_HOLD != 0, hold counter ≥ MAX_HOLD, owner hmastlock == 0, another master requests s, and owner htrans == NONSEQ or IDLE (burst boundary only).
  - On release with other requests pending, arbitrate on the same edge and excluding the releasing owner: immediate handover to the new owner.
  - Locked owner (hmastlock=1) is never released by (c); it is released only by (a) or (b).
- Hold counter: increments in OWNED on each s_hready=1 cycle, saturates at MAX_HOLD, clears on every grant.
- Round-robin (ARB_MODE 0): per-slave pointer; search masters pointer+1 … pointer+NUM_MASTERS modulo NUM_MASTERS, first requester wins; pointer := winner on grant.
- Fixed (ARB_MODE 1): lowest-index requester wins; pointer unused.
- Data-phase tracking: on an edge with s_hready[s]=1, s_data_valid := s_hsel and owner htrans ∈ {NONSEQ, SEQ}, and s_data_owner := s_addr_owner. Both hold while s_hready[s]=0.
- m_hgrant[i] = 1 iff some slave in OWNED has owner i. A master with a request but no grant must hold its address phase.

## Timing
- Reset (hresetn low at edge):
  - every output 0
  - all FSMs FREE
  - counters 0
  - RR pointers = NUM_MASTERS-1, so master 0 is first
- Reset mid-burst drops ownership on that edge with no handover.
- Outputs registered. A request visible in cycle N with slave FREE and hready=1 gives s_hsel/m_hgrant in cycle N+1.
- s_hready low freezes the FSM, owner, counter and data-phase registers; requests queue.
- Simultaneous requests in FREE are resolved by the mode rule. Release plus new request on the same edge means the new owner is visible the next cycle with no FREE gap.
- The pointer wraps modulo NUM_MASTERS with no dead slot.

## Test plan
- Reset, then master 0 NONSEQ to 0x0000_0010 (slave 0) → cycle+1: s_hsel[0]=1, s_addr_owner[0]=0, m_hgrant=0001; next hready edge: s_data_valid[0]=1, s_data_owner[0]=0.
- RR mode, masters 0–3 all continuously requesting slave 1 (0x4000_0000), each going IDLE one cycle after grant → owners in order 0,1,2,3,0.
- Fixed mode, masters 1 and 3 request slave 2 together → master 1 granted; master 3 granted only after master 1 goes IDLE.
- MAX_HOLD=4, master 2 running back-to-back INCR4 bursts to slave 3 unlocked, master 0 waiting → master 2 loses ownership at the first NONSEQ after 4 hready cycles; master 0 owns the next cycle. Repeat with hmastlock=1 → master 2 keeps ownership until IDLE.
- s_hready[0] held low 5 cycles while owner goes IDLE and another master requests → no owner change until hready=1, then handover on that edge.
- hresetn asserted mid-burst → all outputs 0 on the next cycle; after release, master 0 wins the first contention in RR mode.
